// File: rtl/updown_counter_n_if.sv
// Control/status bundle for updown_counter_n. The master drives the count controls and the slave is the counter.
// Handshake: no valid/ready. Every control is sampled on each rising clk edge; q and ovf are registered; tc_up/tc_dn are combinational.
// Sticky-overflow signals exist only when UDC_STICKY_OVF_EN is defined.
interface updown_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc_up;
  logic             tc_dn;
  logic             ovf;
`ifdef UDC_STICKY_OVF_EN
  logic             ovf_clr;
  logic             ovf_sticky;

  modport master (
    output en, up, down, load, d, sat, ovf_clr,
    input  q, tc_up, tc_dn, ovf, ovf_sticky
  );
  modport slave (
    input  en, up, down, load, d, sat, ovf_clr,
    output q, tc_up, tc_dn, ovf, ovf_sticky
  );
`else
  modport master (
    output en, up, down, load, d, sat,
    input  q, tc_up, tc_dn, ovf
  );
  modport slave (
    input  en, up, down, load, d, sat,
    output q, tc_up, tc_dn, ovf
  );
`endif
endinterface

// File: rtl/updown_counter_n.sv
// Parametrised modulo-MODULUS up/down counter with load, wrap/saturate mode, cascade terminal counts and an overflow pulse.
// Optional macro UDC_STICKY_OVF_EN adds a sticky overflow flag with a clear input.
module updown_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic                 clk,
  input logic                 reset,
  updown_counter_n_if.slave   bus
);
  // Both constants are built at WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX     = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             step_up;
  logic             step_dn;
  logic             at_max;
  logic             at_zero;

  assign step_up = bus.en & bus.up;
  assign step_dn = bus.en & ~bus.up & bus.down;
  assign at_max  = (q_reg == MAX);
  assign at_zero = (q_reg == '0);

  always_comb begin
    q_next   = q_reg;
    ovf_next = 1'b0;
    if (bus.load) begin
      q_next = ({1'b0, bus.d} >= MOD_EXT) ? MAX : bus.d;
    end else if (step_up) begin
      if (at_max) begin
        ovf_next = 1'b1;
        q_next   = bus.sat ? q_reg : '0;
      end else begin
        q_next = q_reg + WIDTH'(1);
      end
    end else if (step_dn) begin
      if (at_zero) begin
        ovf_next = 1'b1;
        q_next   = bus.sat ? q_reg : MAX;
      end else begin
        q_next = q_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
    end
  end

  assign bus.q     = q_reg;
  assign bus.ovf   = ovf_reg;
  // Combinational so the next cascade stage steps on the same edge; deliberately blind to load and sat.
  assign bus.tc_up = step_up & at_max;
  assign bus.tc_dn = step_dn & at_zero;

`ifdef UDC_STICKY_OVF_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_reg <= 1'b0;
    end else if (ovf_next) begin
      sticky_reg <= 1'b1;
    end else if (bus.ovf_clr) begin
      sticky_reg <= 1'b0;
    end
  end

  assign bus.ovf_sticky = sticky_reg;
`endif
endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised synchronous up/down counter. It is the generalised successor to the fixed 4-bit T-flip-flop up/down counter.
- Adds configurable width and modulus, count enable, parallel load, a wrap/saturate mode, and cascade terminal-count outputs.
- Used as a building block for timers, address generators and multi-digit (e.g. BCD, MODULUS=10) counter chains.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..16.
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH; default gives full binary range.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; gates up/down counting only, not load.
up  input  1  count-up request.
down  input  1  count-down request.
load  input  1  parallel load strobe.
d  input  WIDTH  parallel load value.
sat  input  1  mode select: 0 = wrap, 1 = saturate at range ends.
q  output  WIDTH  current count, registered.
tc_up  output  1  combinational up terminal count: en & up & (q == MODULUS-1).
tc_dn  output  1  combinational down terminal count: en & ~up & down & (q == 0).
ovf  output  1  registered one-cycle pulse following any wrap or saturate-blocked step.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset drives q=0 and ovf=0 on the next rising edge.
  - Reset has priority over every other input.
  - Asserting reset mid-count discards the in-flight step.
- Priority per edge: reset > load > (en & up) > (en & down) > hold.
- Load: q <= d.
  - If d >= MODULUS, q <= MODULUS-1 (clamp).
  - Load ignores en and sat, and never sets ovf.
- Direction: up=1 counts up regardless of down. This up-wins rule is retained from the existing counter; up=down=1 is therefore a legal count-up, not an error.
- Count up, q < MODULUS-1: q <= q+1.
- Count up, q == MODULUS-1:
  - sat=0: q <= 0.
  - sat=1: q holds.
  - Either case: ovf <= 1 for the following cycle.
- Count down, q > 0: q <= q-1.
- Count down, q == 0:
  - sat=0: q <= MODULUS-1.
  - sat=1: q holds.
  - Either case: ovf <= 1 for the following cycle.
- ovf is 0 on every edge that does not take a boundary step. It is a pulse only, one cycle wide per event; back-to-back boundary steps (sat=1 holding at an end) keep it high.
- en=0, or up=down=0: q holds and ovf <= 0.
- tc_up/tc_dn are purely combinational from q, en, up and down, for zero-latency cascading: the next stage's en is driven from this stage's tc_up|tc_dn.
  - Both outputs are independent of sat and load.
  - A consumer must qualify them with ~load where needed.
- Arithmetic: all compares use WIDTH-bit unsigned values. When MODULUS == 2**WIDTH, the MODULUS-1 constant is all-ones and must not overflow at elaboration; compute it at WIDTH+1 bits.
- q must never hold a value >= MODULUS after any edge.
- Latency: q reflects a step one clock after the edge-sampled inputs.

Optional Feature:
Macro UDC_STICKY_OVF_EN.
- Defined: adds input ovf_clr (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky sets on any edge where ovf would be set.
  - It clears on reset, or on ovf_clr=1.
  - If set and clear coincide on the same edge, set wins.
  - ovf_sticky resets to 0.
- Not defined: ovf_clr and ovf_sticky do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=4, MODULUS=16, sat=0: reset, then en=up=1 for 17 cycles -> q 0,1..15,0,1; ovf high exactly the cycle after q 15->0; tc_up=1 while q=15.
- WIDTH=4, MODULUS=10, sat=0: en=down=1 from q=0 -> q 9,8..0,9; ovf pulses after 0->9; tc_dn=1 at q=0. Then load d=12 -> q=9.
- sat=1, MODULUS=10: count up from 8 for 4 cycles -> q 9,9,9,9; ovf high 3 consecutive cycles. Then count down from 0 -> q stays 0, ovf=1.
- Priority: up=down=1, en=1 -> q increments. Load=1 with up=1 and d=5 -> q=5. en=0 with up=1 -> q holds; load still works with en=0.
- Reset mid-operation: counting up at q=7 with reset=1 for one cycle -> q=0, ovf=0 next edge, counting resumes 1,2... Two 4-bit instances cascaded via tc_up -> carry into the upper stage exactly at the lower-stage 15->0 step.
- With UDC_STICKY_OVF_EN: wrap -> ovf_sticky=1 and stays set across 5 idle cycles. ovf_clr=1 coinciding with a new wrap -> stays 1. ovf_clr=1 alone -> 0.
